// File: rtl/uart_out_mux_block_pkg.sv
// Shared types and widths for the UART output demultiplexer.
// Holds the byte and channel widths and the pair-parser state encoding.
package uart_out_mux_block_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CHAN_W = 8;

    typedef enum logic [1:0] {
        ADDR_WAIT = 2'd0,
        ADDR_ACK  = 2'd1,
        DATA_WAIT = 2'd2,
        DATA_ACK  = 2'd3
    } state_e;

endpackage

// File: rtl/uart_out_mux_block_if.sv
// Fifo-side and UART-side signals of the output mux.
// master = the mux itself, slave = fifo plus UART bank.
interface uart_out_mux_block_if #(
    parameter int unsigned UART_COUNT = 1
) ();
    import uart_out_mux_block_pkg::*;

    logic                  fifo_empty;
    logic                  fifo_read;
    logic [BYTE_W-1:0]     fifo_data;
    logic [UART_COUNT-1:0] write;
    logic [BYTE_W-1:0]     data;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_read,
        output write,
        output data
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_read,
        input  write,
        input  data
    );

endinterface

// File: rtl/uart_out_mux_block_dec.sv
// Channel index to one-hot UART select, with an in-range flag.
// Indices at or above UART_COUNT decode to all-zero.
module uart_out_mux_block_dec
    import uart_out_mux_block_pkg::*;
#(
    parameter int unsigned UART_COUNT = 1
) (
    input  logic [CHAN_W-1:0]     chan,
    output logic [UART_COUNT-1:0] onehot_c,
    output logic                  in_range_c
);

    always_comb begin
        in_range_c = (32'(chan) < UART_COUNT);
        onehot_c   = '0;
        if (in_range_c) begin
            onehot_c = UART_COUNT'(1) << chan;
        end
    end

endmodule

// File: rtl/uart_out_mux_block.sv
// Splits a fifo byte stream of (channel, payload) pairs into one-hot
// write strobes for a bank of UART transmitters.
module uart_out_mux_block
    import uart_out_mux_block_pkg::*;
#(
    parameter int unsigned UART_COUNT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_out_mux_block_if.master  bus
);

    state_e                state_q, state_d;
    logic [CHAN_W-1:0]     chan_q, chan_d;
    logic [BYTE_W-1:0]     data_q, data_d;
    logic [UART_COUNT-1:0] write_q, write_d;
    logic                  fifo_read_c;
    logic [UART_COUNT-1:0] sel_onehot_c;
    logic                  sel_in_range_c;

    uart_out_mux_block_dec #(
        .UART_COUNT (UART_COUNT)
    ) u_dec (
        .chan       (chan_q),
        .onehot_c   (sel_onehot_c),
        .in_range_c (sel_in_range_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ADDR_WAIT;
            chan_q  <= '0;
            data_q  <= '0;
            write_q <= '0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            data_q  <= data_d;
            write_q <= write_d;
        end
    end

    // Pair parser: pop address, settle one cycle, pop payload, strobe one cycle.
    always_comb begin
        state_d     = state_q;
        chan_d      = chan_q;
        data_d      = data_q;
        write_d     = '0;
        fifo_read_c = 1'b0;
        unique case (state_q)
            ADDR_WAIT: begin
                if (!bus.fifo_empty) begin
                    fifo_read_c = 1'b1;
                    chan_d      = CHAN_W'(bus.fifo_data);
                    state_d     = ADDR_ACK;
                end
            end
            ADDR_ACK: begin
                state_d = DATA_WAIT;
            end
            DATA_WAIT: begin
                if (!bus.fifo_empty) begin
                    fifo_read_c = 1'b1;
                    write_d     = sel_onehot_c;
                    state_d     = DATA_ACK;
                    // Out-of-range payloads are dropped and leave data untouched.
                    if (sel_in_range_c) begin
                        data_d = bus.fifo_data;
                    end
                end
            end
            DATA_ACK: begin
                state_d = ADDR_WAIT;
            end
            default: begin
                state_d = ADDR_WAIT;
            end
        endcase
    end

    // The pop strobe is combinational so the fifo advances in the accepting cycle.
    assign bus.fifo_read = fifo_read_c & ~reset;
    assign bus.write     = write_q;
    assign bus.data      = data_q;

endmodule

// File: tb/tb_uart_out_mux_block.sv
// Directed and random checks of uart_out_mux_block with 1 and 4 UART channels.
module tb_uart_out_mux_block;

    typedef struct packed {
        logic [3:0] w;
        logic [7:0] d;
        int         cyc;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic mon_en = 1'b0;

    logic [7:0] q4[$];
    logic [7:0] q1[$];
    ev_t        obs4[$];
    ev_t        obs1[$];
    ev_t        exp4[$];
    ev_t        exp1[$];
    int         reads4 = 0;
    int         reads1 = 0;
    logic       prev_rd4 = 1'b0;
    logic       prev_rd1 = 1'b0;

    logic       pop4, pop1, rst_s;

    uart_out_mux_block_if #(.UART_COUNT(4)) if4 ();
    uart_out_mux_block_if #(.UART_COUNT(1)) if1 ();

    uart_out_mux_block #(.UART_COUNT(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (if4)
    );

    uart_out_mux_block #(.UART_COUNT(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural show-ahead fifos sharing clk and reset with the DUTs.
    initial begin
        if4.fifo_empty = 1'b1;
        if4.fifo_data  = 8'h00;
        if1.fifo_empty = 1'b1;
        if1.fifo_data  = 8'h00;
        forever begin
            @(posedge clk);
            pop4  = if4.fifo_read;
            pop1  = if1.fifo_read;
            rst_s = reset;
            #1;
            if (rst_s) begin
                q4.delete();
                q1.delete();
            end else begin
                if (pop4 && q4.size() != 0) void'(q4.pop_front());
                if (pop1 && q1.size() != 0) void'(q1.pop_front());
            end
            if4.fifo_empty = (q4.size() == 0);
            if4.fifo_data  = (q4.size() != 0) ? q4[0] : 8'h00;
            if1.fifo_empty = (q1.size() == 0);
            if1.fifo_data  = (q1.size() != 0) ? q1[0] : 8'h00;
        end
    end

    // Protocol monitor and write recorder, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            check("rd_empty4", 32'(if4.fifo_read & if4.fifo_empty), 32'd0);
            check("rd_b2b4",   32'(if4.fifo_read & prev_rd4), 32'd0);
            check("rd_rst4",   32'(if4.fifo_read & reset), 32'd0);
            check("onehot4",   32'($countones(if4.write) <= 1), 32'd1);
            check("rd_empty1", 32'(if1.fifo_read & if1.fifo_empty), 32'd0);
            check("rd_b2b1",   32'(if1.fifo_read & prev_rd1), 32'd0);
            check("rd_rst1",   32'(if1.fifo_read & reset), 32'd0);
            if (if4.write != 4'd0) begin
                check("latency4", 32'(prev_rd4), 32'd1);
                obs4.push_back('{w: if4.write, d: if4.data, cyc: cyc});
            end
            if (if1.write != 1'b0) begin
                check("latency1", 32'(prev_rd1), 32'd1);
                obs1.push_back('{w: 4'(if1.write), d: if1.data, cyc: cyc});
            end
            if (if4.fifo_read) reads4++;
            if (if1.fifo_read) reads1++;
        end
        prev_rd4 = if4.fifo_read;
        prev_rd1 = if1.fifo_read;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int         base;
        int         c;
        logic [7:0] p;
        logic [7:0] last4;
        logic [7:0] last1;

        cycles(2);
        check("rst_write4", 32'(if4.write), 32'd0);
        check("rst_data4",  32'(if4.data),  32'd0);
        check("rst_write1", 32'(if1.write), 32'd0);
        check("rst_data1",  32'(if1.data),  32'd0);
        check("rst_read4",  32'(if4.fifo_read), 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Idle with an empty fifo.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_read4",  32'(if4.fifo_read), 32'd0);
            check("idle_write4", 32'(if4.write), 32'd0);
            check("idle_data4",  32'(if4.data), 32'd0);
        end
        cycles(1);

        // Single channel: address, then payload a few cycles later.
        obs1.delete();
        base = reads1;
        q1.push_back(8'h00);
        cycles(5);
        q1.push_back(8'h88);
        cycles(8);
        check("u1_reads", 32'(reads1 - base), 32'd2);
        check("u1_nwr",   32'(obs1.size()), 32'd1);
        if (obs1.size() >= 1) begin
            check("u1_w", 32'(obs1[0].w), 32'd1);
            check("u1_d", 32'(obs1[0].d), 32'h88);
        end

        // Back-to-back pairs to channels 2 and 3.
        obs4.delete();
        q4.push_back(8'h02); q4.push_back(8'h41);
        q4.push_back(8'h03); q4.push_back(8'h42);
        cycles(12);
        check("b2b_nwr", 32'(obs4.size()), 32'd2);
        if (obs4.size() >= 2) begin
            check("b2b_w0",  32'(obs4[0].w), 32'h4);
            check("b2b_d0",  32'(obs4[0].d), 32'h41);
            check("b2b_w1",  32'(obs4[1].w), 32'h8);
            check("b2b_d1",  32'(obs4[1].d), 32'h42);
            check("b2b_gap", 32'(obs4[1].cyc - obs4[0].cyc), 32'd4);
        end

        // Out-of-range channel consumes both bytes and writes nothing.
        base = reads4;
        q4.push_back(8'h07); q4.push_back(8'h55);
        cycles(10);
        check("oor_reads", 32'(reads4 - base), 32'd2);
        check("oor_nwr",   32'(obs4.size()), 32'd2);
        check("oor_data",  32'(if4.data), 32'h42);

        // Reset after an address byte discards the half pair.
        obs4.delete();
        q4.push_back(8'h01);
        cycles(3);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        check("mid_rst_data",  32'(if4.data), 32'd0);
        check("mid_rst_write", 32'(if4.write), 32'd0);
        q4.push_back(8'h00); q4.push_back(8'h99);
        cycles(10);
        check("mid_nwr", 32'(obs4.size()), 32'd1);
        if (obs4.size() >= 1) begin
            check("mid_w", 32'(obs4[0].w), 32'h1);
            check("mid_d", 32'(obs4[0].d), 32'h99);
        end

        // Random pairs, some addressed beyond the bank.
        obs4.delete(); obs1.delete(); exp4.delete(); exp1.delete();
        last4 = 8'h00;
        last1 = 8'h00;
        for (int i = 0; i < 16; i++) begin
            c = int'($urandom_range(0, 5));
            p = 8'($urandom);
            q4.push_back(8'(c)); q4.push_back(p);
            if (c < 4) begin
                exp4.push_back('{w: 4'(1 << c), d: p, cyc: 0});
                last4 = p;
            end
            c = int'($urandom_range(0, 2));
            p = 8'($urandom);
            q1.push_back(8'(c)); q1.push_back(p);
            if (c < 1) begin
                exp1.push_back('{w: 4'h1, d: p, cyc: 0});
                last1 = p;
            end
        end
        cycles(16 * 4 + 10);
        check("rnd_nwr4", 32'(obs4.size()), 32'(exp4.size()));
        for (int i = 0; i < exp4.size() && i < obs4.size(); i++) begin
            check($sformatf("rnd4_w%0d", i), 32'(obs4[i].w), 32'(exp4[i].w));
            check($sformatf("rnd4_d%0d", i), 32'(obs4[i].d), 32'(exp4[i].d));
        end
        check("rnd_nwr1", 32'(obs1.size()), 32'(exp1.size()));
        for (int i = 0; i < exp1.size() && i < obs1.size(); i++) begin
            check($sformatf("rnd1_d%0d", i), 32'(obs1[i].d), 32'(exp1[i].d));
        end
        check("rnd_last4", 32'(if4.data), 32'(last4));
        check("rnd_last1", 32'(if1.data), 32'(last1));
        check("rnd_drain4", 32'(q4.size()), 32'd0);
        check("rnd_drain1", 32'(q1.size()), 32'd0);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
